mem_bus_responder: RTL and testbench
====================================

// Module: mem_bus_responder
// PURPOSE
//  Memory-side responder for the DMA read/write request-grant interface.
//  Accepts read and write requests, arbitrates between them, issues a grant,
//  then streams read beats out or absorbs write beats into a local RAM.
//  Sits between the DMA engine's read/write channel FSMs and on-chip storage.
// PARAMETERS
//  DW         32  data word width
//  AW         8   word address width; RAM depth = 2**AW
//  LW         4   burst-length field width; beats = len+1 (1..2**LW)
//  GRANT_WAIT 2   cycles in MEM_ARB before grant pulse (>=0)
// PORTS
//  clk       in  1   single clock, all logic on rising edge
//  reset_n   in  1   synchronous, active-low reset
//  rd_req    in  1   read request; held by requester until rd_grant
//  rd_addr   in  AW  read start word address (sampled with winning req)
//  rd_len    in  LW  read beats minus one
//  rd_grant  out 1   one-cycle grant pulse for read
//  rd_valid  out 1   read data beat valid
//  rd_data   out DW  read data
//  rd_last   out 1   final read beat, coincident with rd_valid
//  wr_req    in  1   write request; held until wr_grant
//  wr_addr   in  AW  write start word address
//  wr_len    in  LW  write beats minus one
//  wr_grant  out 1   one-cycle grant pulse for write
//  wr_valid  in  1   write beat valid
//  wr_data   in  DW  write data
//  wr_ready  out 1   responder can accept a write beat
//  wr_done   out 1   one-cycle pulse after last write beat committed
//  busy      out 1   high in any state other than MEM_IDLE
// BEHAVIOUR
//  Reset: all outputs 0, rd_data 0, FSM MEM_IDLE, rr pointer favours read.
//  RAM contents not reset.
//  FSM: MEM_IDLE -> MEM_ARB -> MEM_RD_GRANT -> MEM_RD_BURST -> MEM_IDLE;
//    MEM_IDLE -> MEM_ARB -> MEM_WR_GRANT -> MEM_WR_BURST -> MEM_WR_DONE -> MEM_IDLE.
//  MEM_IDLE: on any req, latch winner's addr/len/direction, go MEM_ARB.
//  Both reqs in the same cycle: winner = rr pointer; pointer flips to the
//    other direction after each completed burst.
//  MEM_ARB: wait GRANT_WAIT cycles; GRANT_WAIT=0 goes to grant next cycle.
//    If the latched req drops before the count ends: back to MEM_IDLE,
//    no grant, rr unchanged.
//  MEM_x_GRANT: grant high exactly this one cycle; RAM read of start addr issued.
//  MEM_RD_BURST: RAM read latency 1; first rd_valid the cycle after rd_grant.
//    One beat per cycle, no backpressure; addr increments mod 2**AW.
//    rd_last on beat len; then MEM_IDLE.
//  MEM_WR_BURST: wr_ready=1; beat written when wr_valid&&wr_ready;
//    addr increments mod 2**AW. Idle cycles (wr_valid=0) allowed and do
//    not advance. After beat len, wr_ready drops the next cycle ->
//    MEM_WR_DONE (wr_done=1 one cycle) -> MEM_IDLE.
//  Beat counter LW bits, counts 0..len; len = 2**LW-1 must not overflow.
//  Requests arriving during a burst are ignored until MEM_IDLE; a held req
//    re-enters arbitration the cycle after return to MEM_IDLE.
//  reset_n low mid-burst: burst abandoned, outputs 0 next edge; partially
//    written words remain in RAM.
//  Read-after-write to same addr in a later burst returns the written data.
// STRUCTURE
//  Package mem_pkg: typedef enum mem_state_t {MEM_IDLE, MEM_ARB,
//    MEM_RD_GRANT, MEM_RD_BURST, MEM_WR_GRANT, MEM_WR_BURST, MEM_WR_DONE};
//    direction enum MEM_DIR_RD/MEM_DIR_WR for rr pointer.
//  Sub-module mem_ram: single-port sync RAM (DW x 2**AW), 1-cycle read,
//    write-enable port; responder owns all sequencing.
// TESTING
//  1 rd_req, addr=0x10, len=3 on preloaded RAM -> rd_grant after
//    GRANT_WAIT+1 cycles; 4 consecutive rd_valid, data RAM[0x10..0x13],
//    rd_last on 4th.
//  2 wr_req, addr=0x20, len=1; data A5A5A5A5, 5A5A5A5A with one idle cycle
//    between -> wr_grant pulse, both words stored, wr_done once;
//    then read 0x20 len=1 returns the same words.
//  3 rd_req and wr_req same cycle from reset -> read granted first;
//    write granted after read burst; next simultaneous pair -> write first.
//  4 wr_req, addr=0xFF, len=2 (AW=8) -> words land at 0xFF, 0x00, 0x01.
//  5 rd_req dropped in MEM_ARB -> no rd_grant, FSM MEM_IDLE, busy low.
//  6 reset_n low on 2nd beat of len=7 read -> rd_valid/busy 0 next cycle;
//    a fresh request afterwards completes normally.

Source files
------------

// File: rtl/mem_bus_responder_pkg.sv
// Shared types for the memory-side DMA responder: FSM states and the round-robin direction.
// Combinational helpers only; no latency or flow-control behaviour lives here.
package mem_pkg;

  typedef enum logic [2:0] {
    MEM_IDLE,
    MEM_ARB,
    MEM_RD_GRANT,
    MEM_RD_BURST,
    MEM_WR_GRANT,
    MEM_WR_BURST,
    MEM_WR_DONE
  } mem_state_t;

  typedef enum logic {
    MEM_DIR_RD = 1'b0,
    MEM_DIR_WR = 1'b1
  } mem_dir_t;

  // MEM_ARB is always visited for at least one cycle, even with no extra wait.
  function automatic int arb_cycles(input int grant_wait);
    return (grant_wait < 1) ? 1 : grant_wait;
  endfunction

endpackage

// File: rtl/mem_bus_responder_ram.sv
// Single-port synchronous RAM, DW x 2**AW, registered read data one cycle after the address.
// No flow control: a write and a read of the same address in one cycle returns the old word.
module mem_ram #(
  parameter int DW = 32,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Arbitrates DMA read/write requests, grants one, then streams read beats or absorbs write beats.
// Grant GRANT_WAIT+1 cycles after request, read data 1 cycle after grant; reads have no backpressure, writes stall on wr_valid.
module mem_bus_responder
  import mem_pkg::*;
#(
  parameter int DW         = 32,
  parameter int AW         = 8,
  parameter int LW         = 4,
  parameter int GRANT_WAIT = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  input  logic [LW-1:0] rd_len,
  output logic          rd_grant,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [LW-1:0] wr_len,
  output logic          wr_grant,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  output logic          wr_done,
  output logic          busy
);

  localparam int ARB_CYC = arb_cycles(GRANT_WAIT);
  localparam int WCW     = (ARB_CYC > 1) ? $clog2(ARB_CYC) : 1;

  mem_state_t    state_q, state_d;
  mem_dir_t      dir_q, dir_d;
  mem_dir_t      rr_q, rr_d;
  mem_dir_t      win;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] beat_q, beat_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;

  logic          req_held;
  logic          arb_done;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_rdata;

  mem_ram #(
    .DW(DW),
    .AW(AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (wr_data),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= MEM_IDLE;
      dir_q   <= MEM_DIR_RD;
      rr_q    <= MEM_DIR_RD;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      rr_q    <= rr_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign req_held = (dir_q == MEM_DIR_RD) ? rd_req : wr_req;
  assign arb_done = (wcnt_q == WCW'(ARB_CYC - 1));

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    rr_d     = rr_q;
    addr_d   = addr_q;
    len_d    = len_q;
    beat_d   = beat_q;
    wcnt_d   = wcnt_q;
    win      = MEM_DIR_RD;
    rd_grant = 1'b0;
    rd_valid = 1'b0;
    rd_last  = 1'b0;
    wr_grant = 1'b0;
    wr_ready = 1'b0;
    wr_done  = 1'b0;
    ram_we   = 1'b0;
    ram_addr = addr_q;

    unique case (state_q)
      MEM_IDLE: begin
        if (rd_req || wr_req) begin
          if (rd_req && wr_req) win = rr_q;
          else                  win = rd_req ? MEM_DIR_RD : MEM_DIR_WR;
          dir_d   = win;
          addr_d  = (win == MEM_DIR_RD) ? rd_addr : wr_addr;
          len_d   = (win == MEM_DIR_RD) ? rd_len : wr_len;
          wcnt_d  = '0;
          state_d = MEM_ARB;
        end
      end
      MEM_ARB: begin
        if (!req_held) begin
          state_d = MEM_IDLE;
        end else if (arb_done) begin
          state_d = (dir_q == MEM_DIR_RD) ? MEM_RD_GRANT : MEM_WR_GRANT;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      MEM_RD_GRANT: begin
        // addr_q runs one word ahead of the beat on rd_data from here on.
        rd_grant = 1'b1;
        addr_d   = addr_q + 1'b1;
        beat_d   = '0;
        state_d  = MEM_RD_BURST;
      end
      MEM_RD_BURST: begin
        rd_valid = 1'b1;
        rd_last  = (beat_q == len_q);
        addr_d   = addr_q + 1'b1;
        beat_d   = beat_q + 1'b1;
        if (beat_q == len_q) begin
          rr_d    = MEM_DIR_WR;
          state_d = MEM_IDLE;
        end
      end
      MEM_WR_GRANT: begin
        wr_grant = 1'b1;
        beat_d   = '0;
        state_d  = MEM_WR_BURST;
      end
      MEM_WR_BURST: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          ram_we = 1'b1;
          addr_d = addr_q + 1'b1;
          beat_d = beat_q + 1'b1;
          if (beat_q == len_q) state_d = MEM_WR_DONE;
        end
      end
      MEM_WR_DONE: begin
        wr_done = 1'b1;
        rr_d    = MEM_DIR_RD;
        state_d = MEM_IDLE;
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  assign rd_data = rd_valid ? ram_rdata : '0;
  assign busy    = (state_q != MEM_IDLE);

endmodule

// File: tb/tb_mem_bus_responder.sv
// Randomized scoreboard bench for mem_bus_responder against an array-based memory model.
module tb_mem_bus_responder;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int LW = 4;
  localparam int GW = 2;

  localparam logic [1:0] EV_RG = 2'd0;
  localparam logic [1:0] EV_RB = 2'd1;
  localparam logic [1:0] EV_WG = 2'd2;
  localparam logic [1:0] EV_WD = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] data;
    logic        last;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          rd_req, wr_req, wr_valid;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [LW-1:0] rd_len, wr_len;
  logic [DW-1:0] wr_data, rd_data;
  logic          rd_grant, rd_valid, rd_last, wr_grant, wr_ready, wr_done, busy;

  ev_t          exp_q[$];
  logic [31:0]  mem_m [256];
  logic [31:0]  wbuf  [16];
  bit           rr_m;          // 0: read favoured, 1: write favoured
  int           cur_wl, cur_idle;
  int           n_vec = 0;
  int           n_mis = 0;
  bit           started = 0;

  mem_bus_responder #(.DW(DW), .AW(AW), .LW(LW), .GRANT_WAIT(GW)) dut (
    .clk(clk), .reset_n(reset_n),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_grant(rd_grant),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_grant(wr_grant),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .wr_done(wr_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input logic [1:0] kind, input logic [31:0] data, input logic last,
                           input string nm);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_mis++;
      $display("FAIL unexpected_%s: got event with data %0h, expected none (t=%0t)", nm, data, $time);
    end else begin
      e = exp_q.pop_front();
      check({nm, "_kind"}, 64'(kind), 64'(e.kind));
      if (kind == EV_RB) begin
        check("rd_data", 64'(data), 64'(e.data));
        check("rd_last", 64'(last), 64'(e.last));
      end
    end
  endtask

  // Monitor: every visible output event must match the next scoreboard entry.
  always @(negedge clk) begin
    if (started) begin
      if (rd_grant) expect_ev(EV_RG, '0, 1'b0, "rd_grant");
      if (rd_valid) expect_ev(EV_RB, rd_data, rd_last, "rd_beat");
      else if (rd_last) check("rd_last_without_valid", 64'(rd_last), 64'd0);
      if (wr_grant) expect_ev(EV_WG, '0, 1'b0, "wr_grant");
      if (wr_done)  expect_ev(EV_WD, '0, 1'b0, "wr_done");
    end
  end

  // Reference model: a read returns the current memory words, a write replaces them.
  task automatic model_rd(input logic [7:0] a0, input logic [3:0] len);
    logic [7:0] a;
    exp_q.push_back('{kind: EV_RG, data: '0, last: 1'b0});
    for (int i = 0; i <= int'(len); i++) begin
      a = a0 + 8'(i);
      exp_q.push_back('{kind: EV_RB, data: mem_m[a], last: (i == int'(len))});
    end
    rr_m = 1'b1;
  endtask

  task automatic model_wr(input logic [7:0] a0, input logic [3:0] len);
    logic [7:0] a;
    exp_q.push_back('{kind: EV_WG, data: '0, last: 1'b0});
    for (int i = 0; i <= int'(len); i++) begin
      a = a0 + 8'(i);
      mem_m[a] = wbuf[i];
    end
    exp_q.push_back('{kind: EV_WD, data: '0, last: 1'b0});
    rr_m = 1'b0;
  endtask

  // Called in the grant cycle; idle_pos >= 0 inserts one idle before that beat, -1 is random idles.
  task automatic write_beats(input int len, input int idle_pos);
    int  sent = 0;
    int  cyc = 0;
    bit  drove = 0;
    bit  idled = 0;
    while (cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (drove) sent++;
      if (sent == len + 1) begin
        wr_valid = 1'b0;
        drove = 0;
        check("wr_ready_after_last", 64'(wr_ready), 64'd0);
        break;
      end
      check("wr_ready_in_burst", 64'(wr_ready), 64'd1);
      if ((idle_pos < 0 && $urandom_range(0, 3) == 0) || (sent == idle_pos && !idled)) begin
        idled = 1;
        drove = 0;
        wr_valid = 1'b0;
        wr_data = $urandom;
      end else begin
        drove = 1;
        wr_valid = 1'b1;
        wr_data = wbuf[sent];
      end
    end
    wr_valid = 1'b0;
    if (cyc >= 200) check("write_beats_timeout", 64'd1, 64'd0);
  endtask

  task automatic serve(input bit want_rd, input bit want_wr);
    int cyc = 0;
    bit rd_p = want_rd;
    bit wr_p = want_wr;
    bit first = 1;
    while ((rd_p || wr_p || busy) && cyc < 600) begin
      @(posedge clk); #1;
      cyc++;
      if (rd_grant && rd_p) begin
        rd_p = 0;
        rd_req = 1'b0;
        if (first) check("rd_grant_latency", 64'(cyc), 64'(GW + 1));
        first = 0;
      end else if (wr_grant && wr_p) begin
        wr_p = 0;
        wr_req = 1'b0;
        if (first) check("wr_grant_latency", 64'(cyc), 64'(GW + 1));
        first = 0;
        write_beats(cur_wl, cur_idle);
      end
    end
    if (cyc >= 600) check("serve_timeout", 64'd1, 64'd0);
    rd_req = 1'b0;
    wr_req = 1'b0;
  endtask

  task automatic issue(input bit do_rd, input bit do_wr,
                       input logic [7:0] ra, input logic [3:0] rl,
                       input logic [7:0] wa, input logic [3:0] wl,
                       input int idle_pos, input bit keep);
    if (!keep) for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
    cur_wl = int'(wl);
    cur_idle = idle_pos;
    if (do_rd && do_wr) begin
      if (!rr_m) begin model_rd(ra, rl); model_wr(wa, wl); end
      else       begin model_wr(wa, wl); model_rd(ra, rl); end
    end else if (do_rd) model_rd(ra, rl);
    else if (do_wr)     model_wr(wa, wl);
    rd_req = do_rd; rd_addr = ra; rd_len = rl;
    wr_req = do_wr; wr_addr = wa; wr_len = wl;
    serve(do_rd, do_wr);
  endtask

  initial begin
    int          wait_cyc;
    int          kind;
    logic [7:0]  a6;
    reset_n = 1'b0;
    rd_req = 0; wr_req = 0; wr_valid = 0;
    rd_addr = '0; wr_addr = '0; rd_len = '0; wr_len = '0; wr_data = '0;
    rr_m = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl_outputs", 64'({rd_grant, rd_valid, rd_last, wr_grant, wr_ready, wr_done, busy}), 64'd0);
    check("reset_rd_data", 64'(rd_data), 64'd0);
    reset_n = 1'b1;
    started = 1;

    for (int b = 0; b < 16; b++) issue(0, 1, '0, '0, 8'(b * 16), 4'd15, -1, 0);

    // Preloaded read at 0x10, four beats.
    issue(1, 0, 8'h10, 4'd3, '0, '0, -1, 0);

    // Two-beat write with one idle between beats, then read back.
    wbuf[0] = 32'hA5A5A5A5;
    wbuf[1] = 32'h5A5A5A5A;
    issue(0, 1, '0, '0, 8'h20, 4'd1, 1, 1);
    issue(1, 0, 8'h20, 4'd1, '0, '0, -1, 0);

    // Write wrapping past the top of the address space, then read back.
    issue(0, 1, '0, '0, 8'hFF, 4'd2, -1, 0);
    issue(1, 0, 8'hFF, 4'd2, '0, '0, -1, 0);

    // Request withdrawn during arbitration: no grant, back to idle.
    rd_req = 1'b1; rd_addr = 8'h40; rd_len = 4'd2;
    @(posedge clk); #1;
    check("arb_busy", 64'(busy), 64'd1);
    rd_req = 1'b0;
    @(posedge clk); #1;
    check("arb_drop_busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("arb_drop_stays_idle", 64'(busy), 64'd0);

    // Reset asserted on the second beat of an eight-beat read.
    a6 = 8'h30;
    exp_q.push_back('{kind: EV_RG, data: '0, last: 1'b0});
    exp_q.push_back('{kind: EV_RB, data: mem_m[a6], last: 1'b0});
    exp_q.push_back('{kind: EV_RB, data: mem_m[a6 + 8'd1], last: 1'b0});
    rd_req = 1'b1; rd_addr = a6; rd_len = 4'd7;
    wait_cyc = 0;
    while (!rd_grant && wait_cyc < 50) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    check("rst_test_grant_seen", 64'(rd_grant), 64'd1);
    rd_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_rd_data", 64'(rd_data), 64'd0);
    reset_n = 1'b1;
    rr_m = 1'b0;

    // Simultaneous pair from reset: read wins, write follows.
    issue(1, 1, 8'h50, 4'd2, 8'h60, 4'd1, -1, 0);
    // A lone read leaves the pointer on write, so the next pair goes write first.
    issue(1, 0, 8'h70, 4'd0, '0, '0, -1, 0);
    issue(1, 1, 8'h60, 4'd1, 8'h60, 4'd1, -1, 0);

    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 2);
      issue(kind != 1, kind != 0, 8'($urandom), 4'($urandom), 8'($urandom), 4'($urandom), -1, 0);
    end

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    check("final_idle", 64'(busy), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
